// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t   : FSM encoding (IDLE=00, SHIFT=01, DONE=10)
//   WIDTH_DEF : default operand width
//   cnt_w()   : bit counter width able to hold the value WIDTH
package serial_adder_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder cell, purely combinational.
//   x, y : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (y & ci) | (x & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds a + b + cin LSB first, one bit per
// clock, through a single fa_cell.
//   clk, rst_n : clock (rising edge), async active-low reset
//   start      : begin an addition (only looked at in IDLE)
//   a, b, cin  : operands, captured when start is accepted
//   busy       : high in SHIFT and DONE
//   done       : one-cycle pulse, sum/cout valid from that cycle
//   sum, cout  : registered result, held until the next completed add
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_bit;

  fa_cell u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  // SHIFT runs WIDTH shifting cycles (cnt 0..WIDTH-1); the cycle that sees
  // cnt==WIDTH publishes the result and moves to DONE. cnt therefore tops
  // out at WIDTH and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            res_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == CW'(WIDTH)) begin
            sum   <= res_sh;
            cout  <= carry;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB
            res_sh <= {s_bit, res_sh[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= c_bit;
            cnt    <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit and a 4-bit instance,
// hand-computed sums, latency, start-while-busy and mid-operation reset.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full 8-bit addition; done must rise 9 edges after the accept edge.
  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic cv, input logic [7:0] es, input logic ec);
    int k;
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy"}, busy, 1);
    k = 0;
    while (done !== 1'b1 && k < 40) begin tick(); k++; end
    chk({tag, " latency"}, k, 9);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " busy in done"}, busy, 1);
    tick();
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " idle"}, busy, 0);
  endtask

  initial begin
    int k, ndone, nlow, d1, d2;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, ndone, nlow, d1, d2;
    #1;
    tick(); tick();
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum4", sum4, 0);
    rst_n = 1'b1;

    // first start after reset release is taken on the very next edge
    run8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run8("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("a5+5a+1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    run8("ff+00+1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run8("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run8("64+37", 8'h64, 8'h37, 1'b0, 8'h9B, 1'b0);

    // start kept high with different operands while busy: ignored,
    // sum keeps the previous result during SHIFT
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    tick(); tick(); tick();
    chk("busy hold sum", sum, 8'h9B);
    chk("busy hold busy", busy, 1);
    chk("busy hold done", done, 0);
    start = 1'b0;
    k = 3;
    while (done !== 1'b1 && k < 40) begin tick(); k++; end
    chk("ignore latency", k, 9);
    chk("ignore sum", sum, 8'h46);
    chk("ignore cout", cout, 0);
    tick();

    // start held 20 edges, operands change every cycle
    ndone = 0; nlow = 0; d1 = -1; d2 = -1;
    for (int i = 0; i < 22; i++) begin
      a = 8'(16 + i); b = 8'(240 + i); cin = 1'b0; start = (i < 20);
      tick();
      if (busy == 1'b0 && i < 21) nlow++;
      if (done == 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          d1 = i;
          chk("hold op1 sum", sum, 8'h00);
          chk("hold op1 cout", cout, 1);
        end else begin
          d2 = i;
          chk("hold op2 sum", sum, 8'h16);
          chk("hold op2 cout", cout, 1);
        end
      end
    end
    start = 1'b0;
    chk("hold done count", ndone, 2);
    chk("hold done1 edge", d1, 9);
    chk("hold done2 edge", d2, 20);
    chk("hold idle gap", nlow, 1);

    // reset in the 4th SHIFT cycle
    a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre-rst sum", sum, 8'h16);
    #1 rst_n = 1'b0;
    #1;
    chk("mid-rst sum", sum, 0);
    chk("mid-rst cout", cout, 0);
    chk("mid-rst busy", busy, 0);
    chk("mid-rst done", done, 0);
    #1 rst_n = 1'b1;
    run8("post-rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // 4-bit instance: done 5 edges after accept
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    k = 0;
    while (done4 !== 1'b1 && k < 40) begin tick(); k++; end
    chk("w4 latency", k, 5);
    chk("w4 sum", sum4, 4'hF);
    chk("w4 cout", cout4, 1);
    tick();
    a4 = 4'h3; b4 = 4'h5; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    k = 0;
    while (done4 !== 1'b1 && k < 40) begin tick(); k++; end
    chk("w4b latency", k, 5);
    chk("w4b sum", sum4, 4'h8);
    chk("w4b cout", cout4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
